score_keeper: RTL and testbench

Game-score stage that sits directly downstream of the ball/flag game logic and feeds the HEX displays. It samples flagcount, livesCount, levelindex and the end-of-game flags, which are produced in the VGA_VS frame domain. It accumulates a saturating binary score and a high score. It converts the selected value to six packed BCD digits with a sequential double-dabble engine, and the display path consumes those digits directly.

---
 rtl/score_pkg.sv | 33 +++
 rtl/bcd_conv.sv | 73 +++++++
 rtl/score_keeper.sv | 162 ++++++++++++++++
 tb/tb_score_keeper.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
`default_nettype none
// ============================================================================
// Module      : score_pkg
// Description : Shared widths, converter state encoding and double-dabble step
// Revision    : 1.0 - initial release
// ============================================================================
package score_pkg;

    localparam int SCORE_W    = 20;
    localparam int NUM_DIGITS = 6;
    localparam int BCD_W      = 24;
    localparam int DD_W       = BCD_W + SCORE_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } conv_state_t;

    // One double-dabble iteration over {bcd, bin}: add-3 correction, then shift.
    function automatic logic [DD_W-1:0] dd_step(input logic [DD_W-1:0] v);
        logic [DD_W-1:0] t;
        t = v;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (t[SCORE_W+4*i +: 4] >= 4'd5)
                t[SCORE_W+4*i +: 4] = t[SCORE_W+4*i +: 4] + 4'd3;
        end
        return {t[DD_W-2:0], 1'b0};
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_conv.sv
`default_nettype none
// ============================================================================
// Module      : bcd_conv
// Description : Sequential binary-to-BCD converter, one bit per clock
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_conv
    import score_pkg::*;
(
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               start,
    input  logic [SCORE_W-1:0] bin,
    output logic [BCD_W-1:0]   bcd,
    output logic               valid,
    output logic               busy
);

    localparam logic [4:0] c_num_shifts = 5'(SCORE_W);

    conv_state_t       r_state;
    conv_state_t       w_state_next;
    logic [4:0]        r_count;
    logic [DD_W-1:0]   r_sr;
    logic              w_load;
    logic              w_shift;
    logic              w_done;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) r_state <= IDLE;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = LOAD;
            LOAD:    w_state_next = SHIFT;
            SHIFT:   if (r_count == 5'd1) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        busy    = (r_state != IDLE);
        w_load  = (r_state == LOAD);
        w_shift = (r_state == SHIFT);
        w_done  = (r_state == DONE);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_sr    <= '0;
            r_count <= '0;
            bcd     <= '0;
            valid   <= 1'b0;
        end else begin
            valid <= w_done;
            if (w_load) begin
                r_sr    <= {{BCD_W{1'b0}}, bin};
                r_count <= c_num_shifts;
            end else if (w_shift) begin
                r_sr    <= dd_step(r_sr);
                r_count <= r_count - 5'd1;
            end
            if (w_done)
                bcd <= r_sr[DD_W-1:SCORE_W];
        end
    end

endmodule
`default_nettype wire

// File: rtl/score_keeper.sv
`default_nettype none
// ============================================================================
// Module      : score_keeper
// Description : Frame-domain input sync, score/hi-score accumulation, BCD feed
// Revision    : 1.0 - initial release
// ============================================================================
module score_keeper
    import score_pkg::*;
#(
    parameter int FLAG_POINTS = 100,
    parameter int LEVEL_BONUS = 1000,
    parameter int MAX_SCORE   = 999999,
    parameter int SYNC_STAGES = 2
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic [3:0]         flagcount,
    input  logic [2:0]         livesCount,
    input  logic [1:0]         levelindex,
    input  logic               GameOver,
    input  logic               Winscreen,
    input  logic               new_game,
    input  logic               display_sel,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] hi_score,
    output logic [BCD_W-1:0]   bcd_digits,
    output logic               bcd_valid,
    output logic               busy
);

    localparam int c_in_w = 11;
    typedef logic [SCORE_W:0] sum_t;

    localparam sum_t c_flag_pts0   = sum_t'(FLAG_POINTS);
    localparam sum_t c_flag_pts1   = sum_t'(2 * FLAG_POINTS);
    localparam sum_t c_flag_pts2   = sum_t'(3 * FLAG_POINTS);
    localparam sum_t c_flag_pts3   = sum_t'(4 * FLAG_POINTS);
    localparam sum_t c_level_bonus = sum_t'(LEVEL_BONUS);
    localparam sum_t c_max_score   = sum_t'(MAX_SCORE);

    logic [c_in_w-1:0]  r_sync [SYNC_STAGES];
    logic [c_in_w-1:0]  r_sample_q;
    logic [c_in_w-1:0]  w_in;
    logic [c_in_w-1:0]  w_synced;
    logic               w_stable;
    logic [3:0]         w_flag;
    logic [2:0]         w_lives;
    logic [1:0]         w_level;
    logic               w_end;
    logic [3:0]         r_prev_flag;
    logic [1:0]         r_prev_level;
    logic               r_prev_end;
    logic               r_sel_q;
    logic               r_dirty;
    logic               w_flag_evt;
    logic               w_level_evt;
    logic               w_end_rise;
    sum_t               w_flag_pts;
    sum_t               w_life_bonus;
    sum_t               w_sum;
    logic [SCORE_W-1:0] w_score_next;
    logic [SCORE_W-1:0] w_hi_next;
    logic [SCORE_W-1:0] w_bin;
    logic               w_accept;
    logic               w_change;

    assign w_in     = {GameOver, Winscreen, levelindex, livesCount, flagcount};
    assign w_synced = r_sync[SYNC_STAGES-1];
    // Whole snapshot must repeat once so award logic never sees a skewed bus.
    assign w_stable = (w_synced == r_sample_q);
    assign w_flag   = w_synced[3:0];
    assign w_lives  = w_synced[6:4];
    assign w_level  = w_synced[8:7];
    assign w_end    = w_synced[9] | w_synced[10];

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
            r_sample_q <= '0;
        end else begin
            r_sync[0] <= w_in;
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
            r_sample_q <= w_synced;
        end
    end

    // Widened compares keep 15->0 and 3->0 wraps from counting as increments.
    assign w_flag_evt  = w_stable && ({1'b0, w_flag}  == ({1'b0, r_prev_flag}  + 5'd1));
    assign w_level_evt = w_stable && ({1'b0, w_level} == ({1'b0, r_prev_level} + 3'd1));
    assign w_end_rise  = w_stable && w_end && !r_prev_end;

    always_comb begin
        case (w_level)
            2'd0:    w_flag_pts = c_flag_pts0;
            2'd1:    w_flag_pts = c_flag_pts1;
            2'd2:    w_flag_pts = c_flag_pts2;
            default: w_flag_pts = c_flag_pts3;
        endcase

        w_life_bonus = '0;
        if (w_lives[0]) w_life_bonus = w_life_bonus + c_level_bonus;
        if (w_lives[1]) w_life_bonus = w_life_bonus + (c_level_bonus << 1);
        if (w_lives[2]) w_life_bonus = w_life_bonus + (c_level_bonus << 2);

        w_sum = {1'b0, score}
              + (w_flag_evt  ? w_flag_pts   : '0)
              + (w_level_evt ? w_life_bonus : '0);

        if (new_game)
            w_score_next = '0;
        else if (w_sum > c_max_score)
            w_score_next = c_max_score[SCORE_W-1:0];
        else
            w_score_next = w_sum[SCORE_W-1:0];

        w_hi_next = (w_end_rise && (score > hi_score)) ? score : hi_score;
    end

    assign w_change = (w_score_next != score) || (w_hi_next != hi_score)
                   || (display_sel != r_sel_q);
    assign w_accept = r_dirty && !busy;
    assign w_bin    = display_sel ? hi_score : score;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            score        <= '0;
            hi_score     <= '0;
            r_prev_flag  <= '0;
            r_prev_level <= '0;
            r_prev_end   <= 1'b0;
            r_sel_q      <= 1'b0;
            r_dirty      <= 1'b1;
        end else begin
            score    <= w_score_next;
            hi_score <= w_hi_next;
            r_sel_q  <= display_sel;
            if (new_game || w_stable) begin
                r_prev_flag  <= w_flag;
                r_prev_level <= w_level;
            end
            if (w_stable)
                r_prev_end <= w_end;
            // A change in the accept cycle wins so the newest value is reconverted.
            if (w_change)
                r_dirty <= 1'b1;
            else if (w_accept)
                r_dirty <= 1'b0;
        end
    end

    bcd_conv u_bcd_conv (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .start   (r_dirty),
        .bin     (w_bin),
        .bcd     (bcd_digits),
        .valid   (bcd_valid),
        .busy    (busy)
    );

endmodule
`default_nettype wire

// File: tb/tb_score_keeper.sv
`default_nettype none
// ============================================================================
// Module      : tb_score_keeper
// Description : Directed self-checking bench for score_keeper (default and MAX_SCORE=500)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_score_keeper;

    logic        Clk;
    logic        Reset_n;
    logic [3:0]  flagcount;
    logic [2:0]  livesCount;
    logic [1:0]  levelindex;
    logic        GameOver;
    logic        Winscreen;
    logic        new_game;
    logic        display_sel;
    logic [19:0] score, hi_score, sat_score, sat_hi;
    logic [23:0] bcd_digits, sat_bcd;
    logic        bcd_valid, busy, sat_valid, sat_busy;

    int n_cmp = 0;
    int n_err = 0;

    score_keeper dut (
        .Clk(Clk), .Reset_n(Reset_n), .flagcount(flagcount), .livesCount(livesCount),
        .levelindex(levelindex), .GameOver(GameOver), .Winscreen(Winscreen),
        .new_game(new_game), .display_sel(display_sel), .score(score),
        .hi_score(hi_score), .bcd_digits(bcd_digits), .bcd_valid(bcd_valid), .busy(busy)
    );

    score_keeper #(.MAX_SCORE(500)) dut_sat (
        .Clk(Clk), .Reset_n(Reset_n), .flagcount(flagcount), .livesCount(livesCount),
        .levelindex(levelindex), .GameOver(GameOver), .Winscreen(Winscreen),
        .new_game(new_game), .display_sel(display_sel), .score(sat_score),
        .hi_score(sat_hi), .bcd_digits(sat_bcd), .bcd_valid(sat_valid), .busy(sat_busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic wait_score(input logic [19:0] exp, input int max_cyc, input string tag);
        for (int i = 0; i < max_cyc && score !== exp; i++) tick(1);
        check_val(tag, score, exp);
    endtask

    task automatic wait_valid(input int max_cyc, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            tick(1);
            seen = bcd_valid;
        end
        check_val(tag, seen, 1);
    endtask

    task automatic wait_busy(input int max_cyc, input string tag);
        for (int i = 0; i < max_cyc && !busy; i++) tick(1);
        check_val(tag, busy, 1);
    endtask

    task automatic capture(input logic [3:0] f);
        flagcount = f;
        tick(35);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int nb;
        bit seen;

        Reset_n = 1'b0; flagcount = 4'd0; livesCount = 3'd0; levelindex = 2'd0;
        GameOver = 1'b0; Winscreen = 1'b0; new_game = 1'b0; display_sel = 1'b0;
        tick(3);
        check_val("rst_score", score, 0);
        check_val("rst_hi", hi_score, 0);
        check_val("rst_bcd", bcd_digits, 0);
        check_val("rst_valid", bcd_valid, 0);
        check_val("rst_busy", busy, 0);

        // Power-up conversion of zero
        Reset_n = 1'b1;
        cyc = 0; seen = 1'b0;
        while (!seen && cyc < 40) begin
            tick(1);
            cyc++;
            seen = bcd_valid;
        end
        check_val("init_conv_latency", cyc, 23);
        check_val("init_bcd", bcd_digits, 24'h000000);
        check_val("init_score", score, 0);

        // Flag captures at level 0 and level 2
        flagcount = 4'd1;
        wait_score(20'd100, 5, "flag_l0_score");
        wait_valid(30, "flag_l0_valid");
        check_val("flag_l0_bcd", bcd_digits, 24'h000100);
        levelindex = 2'd2;
        tick(8);
        check_val("level_jump_no_award", score, 100);
        flagcount = 4'd2;
        wait_score(20'd400, 5, "flag_l2_score");
        wait_valid(30, "flag_l2_valid");
        check_val("flag_l2_bcd", bcd_digits, 24'h000400);

        // Level bonus together with a same-cycle flag capture
        levelindex = 2'd0;
        tick(8);
        check_val("level_down_no_award", score, 400);
        livesCount = 3'd3;
        tick(8);
        levelindex = 2'd1;
        flagcount  = 4'd3;
        wait_score(20'd3600, 5, "level_flag_score");
        wait_valid(30, "level_flag_valid");
        check_val("level_flag_bcd", bcd_digits, 24'h003600);
        check_val("sat_clamp_big", sat_score, 500);

        // Saturation on the MAX_SCORE=500 instance
        new_game = 1'b1;
        tick(1);
        new_game = 1'b0;
        check_val("newgame_score", score, 0);
        check_val("newgame_sat_score", sat_score, 0);
        levelindex = 2'd0;
        tick(8);
        check_val("newgame_level_down", score, 0);
        capture(4'd4); capture(4'd5); capture(4'd6); capture(4'd7);
        check_val("sat_four", sat_score, 400);
        capture(4'd8);
        check_val("sat_five", sat_score, 500);
        check_val("sat_five_bcd", sat_bcd, 24'h000500);
        check_val("main_five", score, 500);
        flagcount = 4'd9;
        nb = 0;
        repeat (35) begin
            tick(1);
            if (sat_busy || sat_valid) nb++;
        end
        check_val("sat_no_retrigger", nb, 0);
        check_val("sat_six", sat_score, 500);
        check_val("main_six", score, 600);
        capture(4'd10);
        check_val("main_seven", score, 700);

        // High score, new game, display select, flag reset
        GameOver = 1'b1;
        tick(8);
        check_val("hi_on_gameover", hi_score, 700);
        check_val("sat_hi_on_gameover", sat_hi, 500);
        GameOver = 1'b0;
        tick(8);
        new_game = 1'b1;
        tick(1);
        new_game = 1'b0;
        check_val("newgame2_score", score, 0);
        check_val("newgame2_hi", hi_score, 700);
        tick(35);
        display_sel = 1'b1;
        wait_valid(40, "sel_hi_valid");
        check_val("sel_hi_bcd", bcd_digits, 24'h000700);
        flagcount = 4'd0;
        tick(8);
        check_val("flagreset_no_award", score, 0);
        flagcount = 4'd1;
        wait_score(20'd100, 5, "capture_after_flagreset");
        tick(35);

        // Value change mid-conversion: stale result first, then fresh one
        display_sel = 1'b0;
        wait_busy(10, "midconv_busy_rise");
        tick(9);
        flagcount = 4'd2;
        wait_valid(30, "stale_valid");
        check_val("stale_bcd", bcd_digits, 24'h000100);
        wait_valid(30, "fresh_valid");
        check_val("fresh_bcd", bcd_digits, 24'h000200);
        check_val("fresh_score", score, 200);

        // Asynchronous reset during SHIFT
        flagcount = 4'd3;
        wait_busy(12, "abort_busy_rise");
        tick(5);
        #3;
        Reset_n = 1'b0;
        #1;
        check_val("abort_busy", busy, 0);
        check_val("abort_bcd", bcd_digits, 0);
        check_val("abort_score", score, 0);
        check_val("abort_hi", hi_score, 0);
        tick(2);
        Reset_n = 1'b1;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
